sun_pll_lockdet: RTL
====================

// Module: sun_pll_lockdet
// PURPOSE
//  Digital lock detector downstream of the PLL. Clocked by the PLL output CK.
//  Counts CK cycles per CK_REF period and compares the count with the expected
//  multiplication ratio. Asserts LOCKED after a run of in-tolerance periods.
//  Drops LOCKED on repeated out-of-tolerance periods or a missing reference.
// PARAMETERS
//  DIV_RATIO   32  expected CK cycles per CK_REF period (feedback divider ratio)
//  TOL         2   allowed |PERIOD-DIV_RATIO| for a good period
//  LOCK_CNT    8   consecutive good periods required to assert LOCKED
//  UNLOCK_CNT  2   consecutive bad periods that deassert LOCKED
//  CNT_W       8   period counter width; saturates at 2^CNT_W-1
// PORTS
//  CK          in   1      PLL output clock; single clock domain
//  RST         in   1      synchronous reset, active high
//  PWRUP_1V8   in   1      PLL enable (level, CK domain); low = force IDLE
//  CK_REF      in   1      reference clock, asynchronous to CK; sampled as data
//  LOCKED      out  1      PLL lock indication
//  REF_LOST    out  1      no CK_REF rising edge for 2^CNT_W-1 CK cycles
//  PERIOD      out  CNT_W  last measured period in CK cycles
//  PERIOD_VLD  out  1      one-cycle pulse when PERIOD updates
// BEHAVIOUR
//  - Reset (RST=1 at CK rise): all outputs 0, FSM=IDLE, all counters 0, sync flops 0.
//  - CK_REF path: 2-flop synchronizer, then a 3rd flop.
//    ref_edge = s2 & ~s3. The first cycle with ref_edge high is the 3rd CK rise
//    after CK_REF rises (sampling uncertainty +/-1 cycle).
//  - Period counter cnt:
//    * on ref_edge: cnt<=1.
//    * otherwise: cnt<=cnt+1, saturating at 2^CNT_W-1 with no wrap.
//  - FSM states IDLE, ACQ, MEAS, LOCK:
//    * IDLE: cnt, good_cnt and bad_cnt held at 0; LOCKED=0.
//      Go to ACQ when PWRUP_1V8=1.
//    * ACQ: wait for the first ref_edge and go to MEAS.
//      No PERIOD update on this edge (partial period is discarded).
//    * MEAS: on each ref_edge, PERIOD<=cnt and PERIOD_VLD=1 next cycle.
//      good = |cnt-DIV_RATIO|<=TOL, computed with CNT_W+1 signed arithmetic.
//      good: good_cnt++, saturating at LOCK_CNT. bad: good_cnt<=0.
//      When good_cnt reaches LOCK_CNT, go to LOCK; LOCKED=1 in the same cycle
//      the state becomes LOCK.
//    * LOCK: on each ref_edge, update PERIOD/PERIOD_VLD as in MEAS.
//      good: bad_cnt<=0. bad: bad_cnt++.
//      When bad_cnt reaches UNLOCK_CNT: go to MEAS, LOCKED<=0, good_cnt<=0.
//  - REF_LOST: set when cnt reaches saturation in ACQ, MEAS or LOCK.
//    In MEAS/LOCK, also go to ACQ and clear LOCKED, good_cnt and bad_cnt.
//    Cleared on the next ref_edge. A saturated period never produces PERIOD_VLD.
//  - PWRUP_1V8=0 in any state: go to IDLE next cycle and clear LOCKED and REF_LOST.
//    PERIOD holds its last value.
//  - Simultaneous ref_edge and saturation: ref_edge wins; the period is judged bad.
//  - RST overrides PWRUP_1V8 and all other inputs.
//  - Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1. CK_REF period = 32 CK, PWRUP_1V8=1 -> PERIOD=32 on every PERIOD_VLD;
//     LOCKED=1 after the 8th good period following the discarded first edge.
//  2. Locked, then periods of 35 CK -> two bad periods; LOCKED=0 at the 2nd;
//     state MEAS. A single 35 amid 32s keeps LOCKED=1.
//  3. Periods alternating 30/34 -> all good (TOL=2), LOCKED=1 after 8.
//     Periods alternating 29/32 -> good_cnt never reaches 8, LOCKED stays 0.
//  4. Locked, then CK_REF stopped -> REF_LOST=1 exactly when cnt reaches 255;
//     LOCKED=0, state ACQ. On CK_REF restart: REF_LOST=0 at the first edge,
//     and that edge gives no PERIOD_VLD.
//  5. Locked, PWRUP_1V8 pulled low for 1 cycle -> LOCKED=0 next cycle, IDLE;
//     re-lock needs 1 discarded edge plus 8 good periods.
//  6. RST asserted mid-LOCK -> all outputs 0 next cycle including PERIOD.
//     Random CK_REF phase jitter +/-1 CK -> LOCKED still asserted with TOL=2.

Source files
------------

// File: rtl/sun_pll_lockdet.sv
// rtl/sun_pll_lockdet.sv - digital PLL lock detector measuring CK cycles per CK_REF period
//
// Purpose: counts CK cycles between synchronized CK_REF rising edges and judges each
// period against DIV_RATIO +/- TOL. A run of LOCK_CNT good periods asserts LOCKED.
// A run of UNLOCK_CNT bad periods drops it. A reference that stops long enough for
// the counter to saturate raises REF_LOST and restarts acquisition.
//
// Ports:
//   CK          in   PLL output clock, the only clock domain
//   RST         in   synchronous reset, active high
//   PWRUP_1V8   in   detector enable; low forces IDLE
//   CK_REF      in   reference clock, asynchronous, sampled as data
//   LOCKED      out  lock indication
//   REF_LOST    out  counter saturated without a reference edge
//   PERIOD      out  last measured period in CK cycles
//   PERIOD_VLD  out  one-cycle pulse when PERIOD updates
module sun_pll_lockdet #(
  parameter int unsigned DIV_RATIO  = 32,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             PWRUP_1V8,
  input  logic             CK_REF,
  output logic             LOCKED,
  output logic             REF_LOST,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VLD
);

  localparam int unsigned GC_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BC_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;
  localparam logic [1:0] ST_LOCK = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   DIV_V    = (CNT_W + 1)'(DIV_RATIO);
  localparam logic [CNT_W:0]   TOL_V    = (CNT_W + 1)'(TOL);
  localparam logic [GC_W-1:0]  LOCK_V   = GC_W'(LOCK_CNT);
  localparam logic [BC_W-1:0]  UNLOCK_V = BC_W'(UNLOCK_CNT);

  logic             s1_q, s2_q, s3_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GC_W-1:0]  gc_q, gc_d, gc_inc;
  logic [BC_W-1:0]  bc_q, bc_d, bc_inc;
  logic             locked_q, locked_d;
  logic             lost_q, lost_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;

  logic                ref_edge;
  logic [CNT_W-1:0]    cnt_next;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]      diff_abs;
  logic                good;

  assign ref_edge = s2_q & ~s3_q;

  // Free-running count of CK cycles since the last reference edge, no wrap.
  assign cnt_next = ref_edge ? CNT_W'(1) :
                    (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

  // One extra bit keeps the signed difference exact over the whole counter range.
  assign diff     = $signed({1'b0, cnt_q}) - $signed(DIV_V);
  assign diff_abs = diff[CNT_W] ? CNT_W'(0) - diff : diff;
  assign good     = (diff_abs <= TOL_V);

  assign gc_inc = (gc_q == LOCK_V) ? gc_q : gc_q + 1'b1;
  assign bc_inc = bc_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gc_d     = gc_q;
    bc_d     = bc_q;
    locked_d = locked_q;
    lost_d   = lost_q;
    period_d = period_q;
    vld_d    = 1'b0;

    if (!PWRUP_1V8) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      gc_d     = '0;
      bc_d     = '0;
      locked_d = 1'b0;
      lost_d   = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d  = ST_ACQ;
      cnt_d    = '0;
      gc_d     = '0;
      bc_d     = '0;
      locked_d = 1'b0;
    end else begin
      cnt_d = cnt_next;
      if (ref_edge) begin
        // A reference edge always beats saturation in the same cycle.
        lost_d = 1'b0;
        unique case (state_q)
          ST_ACQ: state_d = ST_MEAS;  // partial first period is discarded
          ST_MEAS: begin
            period_d = cnt_q;
            vld_d    = 1'b1;
            if (good) begin
              gc_d = gc_inc;
              if (gc_inc == LOCK_V) begin
                state_d  = ST_LOCK;
                locked_d = 1'b1;
                bc_d     = '0;
              end
            end else begin
              gc_d = '0;
            end
          end
          ST_LOCK: begin
            period_d = cnt_q;
            vld_d    = 1'b1;
            if (good) begin
              bc_d = '0;
            end else if (bc_inc == UNLOCK_V) begin
              state_d  = ST_MEAS;
              locked_d = 1'b0;
              gc_d     = '0;
              bc_d     = '0;
            end else begin
              bc_d = bc_inc;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end else if (cnt_next == CNT_MAX) begin
        lost_d = 1'b1;
        if (state_q == ST_MEAS || state_q == ST_LOCK) begin
          state_d  = ST_ACQ;
          locked_d = 1'b0;
          gc_d     = '0;
          bc_d     = '0;
        end
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gc_q     <= '0;
      bc_q     <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      period_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      s1_q     <= CK_REF;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gc_q     <= gc_d;
      bc_q     <= bc_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
      period_q <= period_d;
      vld_q    <= vld_d;
    end
  end

  assign LOCKED     = locked_q;
  assign REF_LOST   = lost_q;
  assign PERIOD     = period_q;
  assign PERIOD_VLD = vld_q;

endmodule
